// File: rtl/rr_lock_arbiter_if.sv
// rr_lock_arbiter_if: request/grant bundle shared by requesters and the arbiter.
// Revision: 1.0
`default_nettype none

interface rr_lock_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           preempt;

  modport master (
    output request,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  preempt
  );

  modport slave (
    input  request,
    output grant,
    output grant_valid,
    output grant_id,
    output preempt
  );
endinterface

`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: registered round-robin arbiter with burst locking and a hold quantum.
// Revision: 1.0
`default_nettype none

module rr_lock_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_lock_arbiter_if.slave    bus
);
  localparam int          IDW        = $clog2(N);
  localparam logic [7:0]  HOLD_LIMIT = 8'(MAX_HOLD);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   grant_q;
  logic           valid_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] ptr_q;
  logic [7:0]     hold_cnt;
  logic           preempt_q;

  logic [N-1:0]   cand;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] win_next;
  logic [IDW-1:0] scan_idx;
  int             scan;

  logic           own_req;
  logic           do_take;
  logic           do_release;
  logic           do_preempt;
  logic           do_inc;
  logic           do_restart;

  // While granted, the current owner is masked out so a search always yields a different owner.
  always_comb begin
    cand = (state == GRANT) ? (bus.request & ~grant_q) : bus.request;
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan     = (int'(ptr_q) + i) % N;
      scan_idx = IDW'(scan);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    win_next = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    own_req    = bus.request[owner_q];
    do_take    = 1'b0;
    do_release = 1'b0;
    do_preempt = 1'b0;
    do_inc     = 1'b0;
    do_restart = 1'b0;
    case (state)
      IDLE: begin
        do_take = win_found;
      end
      GRANT: begin
        if (!own_req) begin
          do_take    = win_found;
          do_release = !win_found;
        end else if (hold_cnt < HOLD_LIMIT) begin
          do_inc = 1'b1;
        end else if (win_found) begin
          do_take    = 1'b1;
          do_preempt = 1'b1;
        end else begin
          do_restart = 1'b1;
        end
      end
      default: begin
        do_release = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= do_preempt;
      if (do_take) begin
        state    <= GRANT;
        grant_q  <= N'(1) << win_idx;
        valid_q  <= 1'b1;
        owner_q  <= win_idx;
        ptr_q    <= win_next;
        hold_cnt <= 8'd1;
      end else if (do_release) begin
        state    <= IDLE;
        grant_q  <= '0;
        valid_q  <= 1'b0;
        owner_q  <= '0;
        hold_cnt <= '0;
      end else if (do_inc) begin
        hold_cnt <= hold_cnt + 8'd1;
      end else if (do_restart) begin
        hold_cnt <= 8'd1;
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_id    = owner_q;
  assign bus.preempt     = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: directed vector bench over four arbiter configurations.
// Revision: 1.0
`default_nettype none

module tb_rr_lock_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_lock_arbiter_if #(.N(2)) b2 ();
  rr_lock_arbiter_if #(.N(4)) b8 ();
  rr_lock_arbiter_if #(.N(4)) b3 ();
  rr_lock_arbiter_if #(.N(4)) b1 ();

  rr_lock_arbiter #(.N(2), .MAX_HOLD(8)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  rr_lock_arbiter #(.N(4), .MAX_HOLD(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
  rr_lock_arbiter #(.N(4), .MAX_HOLD(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));
  rr_lock_arbiter #(.N(4), .MAX_HOLD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         sel;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int sel, logic r, logic [3:0] req, logic [3:0] g, logic p);
    vec_t v;
    v.sel = sel;
    v.rst = r;
    v.req = req;
    v.gnt = g;
    v.pre = p;
    vecs.push_back(v);
  endfunction

  function automatic logic [31:0] id_of(logic [3:0] g);
    for (int i = 0; i < 4; i++)
      if (g[i]) return 32'(i);
    return 32'd0;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic sample(int sel, output logic [3:0] g, output logic v,
                        output logic [3:0] id, output logic p);
    g = '0; v = 1'b0; id = '0; p = 1'b0;
    case (sel)
      2: begin g = {2'b00, b2.grant}; v = b2.grant_valid; id = {3'b000, b2.grant_id}; p = b2.preempt; end
      8: begin g = b8.grant; v = b8.grant_valid; id = {2'b00, b8.grant_id}; p = b8.preempt; end
      3: begin g = b3.grant; v = b3.grant_valid; id = {2'b00, b3.grant_id}; p = b3.preempt; end
      default: begin g = b1.grant; v = b1.grant_valid; id = {2'b00, b1.grant_id}; p = b1.preempt; end
    endcase
  endtask

  task automatic check_all(string tag, int sel, int idx, logic [3:0] eg, logic ep);
    logic [3:0] g, id;
    logic       v, p;
    sample(sel, g, v, id, p);
    check({tag, ".grant"},       idx, 32'(g),  32'(eg));
    check({tag, ".grant_valid"}, idx, 32'(v),  32'(|eg));
    check({tag, ".grant_id"},    idx, 32'(id), id_of(eg));
    check({tag, ".preempt"},     idx, 32'(p),  32'(ep));
  endtask

  task automatic apply(input vec_t v, int idx);
    rst = v.rst;
    case (v.sel)
      2:       b2.request = v.req[1:0];
      8:       b8.request = v.req;
      3:       b3.request = v.req;
      default: b1.request = v.req;
    endcase
    @(posedge clk);
    #1;
    check_all($sformatf("vec_sel%0d", v.sel), v.sel, idx, v.gnt, v.pre);
  endtask

  initial begin
    b2.request = '0;
    b8.request = '0;
    b3.request = '0;
    b1.request = '0;

    // Rotation: each owner drops one cycle after grant and re-raises; then lone requester 3.
    add(8, 0, 4'b1111, 4'b0001, 0);
    add(8, 0, 4'b1110, 4'b0010, 0);
    add(8, 0, 4'b1101, 4'b0100, 0);
    add(8, 0, 4'b1011, 4'b1000, 0);
    add(8, 0, 4'b0111, 4'b0001, 0);
    add(8, 0, 4'b0000, 4'b0000, 0);
    add(8, 0, 4'b1000, 4'b1000, 0);
    add(8, 0, 4'b1000, 4'b1000, 0);
    add(8, 0, 4'b0000, 4'b0000, 0);
    add(8, 0, 4'b1000, 4'b1000, 0);
    add(8, 0, 4'b0000, 4'b0000, 0);
    // Preemption exactly at the 8-cycle quantum.
    add(8, 0, 4'b0001, 4'b0001, 0);
    for (int i = 0; i < 7; i++) add(8, 0, 4'b0011, 4'b0001, 0);
    add(8, 0, 4'b0011, 4'b0010, 1);
    add(8, 0, 4'b0011, 4'b0010, 0);
    add(8, 0, 4'b0000, 4'b0000, 0);
    // MAX_HOLD=1: every contended cycle rotates; uncontended owner keeps the grant.
    add(1, 0, 4'b0011, 4'b0001, 0);
    add(1, 0, 4'b0011, 4'b0010, 1);
    add(1, 0, 4'b0011, 4'b0001, 1);
    add(1, 0, 4'b0001, 4'b0001, 0);
    add(1, 0, 4'b0000, 4'b0000, 0);
    // MAX_HOLD=3: quantum preemption and regrant of the preempted owner.
    add(3, 0, 4'b0001, 4'b0001, 0);
    add(3, 0, 4'b0101, 4'b0001, 0);
    add(3, 0, 4'b0101, 4'b0001, 0);
    add(3, 0, 4'b0101, 4'b0100, 1);
    add(3, 0, 4'b0101, 4'b0100, 0);
    add(3, 0, 4'b0001, 4'b0001, 0);
    add(3, 0, 4'b0000, 4'b0000, 0);
    // Uncontended burst well past the quantum.
    for (int i = 0; i < 10; i++) add(3, 0, 4'b0010, 4'b0010, 0);
    add(3, 0, 4'b0000, 4'b0000, 0);
    // Reset mid-burst: grant drops without preempt, pointer returns to 0.
    add(3, 0, 4'b0100, 4'b0100, 0);
    add(3, 0, 4'b0100, 4'b0100, 0);
    add(3, 1, 4'b0100, 4'b0000, 0);
    add(3, 0, 4'b0110, 4'b0010, 0);
    add(3, 0, 4'b0110, 4'b0010, 0);
    add(3, 0, 4'b0000, 4'b0000, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_n2", 2, 0, 4'b0000, 1'b0);
    check_all("reset_h8", 8, 0, 4'b0000, 1'b0);
    check_all("reset_h3", 3, 0, 4'b0000, 1'b0);
    check_all("reset_h1", 1, 0, 4'b0000, 1'b0);
    rst = 1'b0;

    // Two-requester arbiter: grant one edge after request, holds, releases, then owner 1.
    b2.request = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_all("n2_hold", 2, i, 4'b0001, 1'b0);
    end
    b2.request = 2'b00;
    @(posedge clk);
    #1;
    check_all("n2_release", 2, 0, 4'b0000, 1'b0);
    b2.request = 2'b10;
    @(posedge clk);
    #1;
    check_all("n2_owner1", 2, 0, 4'b0010, 1'b0);
    b2.request = 2'b00;
    @(posedge clk);
    #1;
    check_all("n2_idle", 2, 0, 4'b0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
